alu_ctrl_decode: RTL and testbench

Execute-stage front end of the RV64 pipeline. Decodes one 32-bit RV64I instruction into the ALU operation code, a sign-extended 64-bit immediate and operand-select controls, then holds the result in a single ID/EX pipeline register. The register has valid/ready handshakes on both sides. It drives the encoding side of the ALU control interface: the ALU consumes `alu_op`, and operand muxes built from `a_sel`/`b_sel` feed its A/B inputs.

---
 rtl/alu_ctrl_decode_pkg.sv | 87 ++++++++
 rtl/alu_ctrl_decode_op_dec.sv | 164 ++++++++++++++++
 rtl/alu_ctrl_decode.sv | 81 ++++++++
 tb/tb_alu_ctrl_decode.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_decode_pkg.sv
// Shared constants for the RV64 execute-stage decode front end: datapath
// widths, ALU operation codes, major opcodes, immediate builders and the
// ID/EX bundle layout.
package alu_ctrl_decode_pkg;

  localparam int DATA_BITS     = 64;
  localparam int ALU_CTRL_BITS = 5;

  // ALU operation codes consumed by the execute stage.
  localparam logic [ALU_CTRL_BITS-1:0] ALU_ADD   = 5'd0;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SUB   = 5'd1;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLL   = 5'd2;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLT   = 5'd3;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLTU  = 5'd4;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_XOR   = 5'd5;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SRL   = 5'd6;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SRA   = 5'd7;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_OR    = 5'd8;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_AND   = 5'd9;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_LUI   = 5'd10;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_AUIPC = 5'd11;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLLW  = 5'd12;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SRLW  = 5'd13;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SRAW  = 5'd14;

  // RV64I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_OP         = 7'b0110011;
  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_OP_32      = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;

  // Decoded bundle held in the ID/EX register.
  typedef struct packed {
    logic [ALU_CTRL_BITS-1:0] alu_op;
    logic [DATA_BITS-1:0]     imm;
    logic                     a_sel;
    logic                     b_sel;
    logic                     w_op;
    logic                     illegal;
  } id_ex_t;

  // Immediate formats, all sign-extended from instr[31].
  function automatic logic [DATA_BITS-1:0] imm_itype(input logic [31:0] ins);
    return {{(DATA_BITS-12){ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [DATA_BITS-1:0] imm_stype(input logic [31:0] ins);
    return {{(DATA_BITS-12){ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [DATA_BITS-1:0] imm_btype(input logic [31:0] ins);
    return {{(DATA_BITS-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [DATA_BITS-1:0] imm_utype(input logic [31:0] ins);
    return {{(DATA_BITS-32){ins[31]}}, ins[31:12], 12'h000};
  endfunction

  function automatic logic [DATA_BITS-1:0] imm_jtype(input logic [31:0] ins);
    return {{(DATA_BITS-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // funct3 to ALU op for the OP/OP-IMM group; alt selects SUB/SRA.
  function automatic logic [ALU_CTRL_BITS-1:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [ALU_CTRL_BITS-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_op_dec.sv
// Purely combinational RV64I decoder: instruction word to ALU op, immediate,
// operand selects, 32-bit-op flag and illegal flag.
module alu_op_dec
  import alu_ctrl_decode_pkg::*;
(
  input  logic [31:0]              instr_i,
  output logic [ALU_CTRL_BITS-1:0] alu_op_o,
  output logic [DATA_BITS-1:0]     imm_o,
  output logic                     a_sel_o,
  output logic                     b_sel_o,
  output logic                     w_op_o,
  output logic                     illegal_o
);

  logic [6:0]               opcode_s;
  logic [2:0]               funct3_s;
  logic [6:0]               funct7_s;
  logic [5:0]               funct6_s;
  logic [DATA_BITS-1:0]     shamt6_s;
  logic [DATA_BITS-1:0]     shamt5_s;
  logic [ALU_CTRL_BITS-1:0] dec_op_s;
  logic [DATA_BITS-1:0]     dec_imm_s;
  logic                     dec_a_s;
  logic                     dec_b_s;
  logic                     dec_w_s;
  logic                     dec_bad_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];
  assign funct6_s = instr_i[31:26];
  assign shamt6_s = {{(DATA_BITS-6){1'b0}}, instr_i[25:20]};
  assign shamt5_s = {{(DATA_BITS-5){1'b0}}, instr_i[24:20]};

  // Per-opcode field decode; legality is collected in dec_bad_s.
  always_comb begin
    dec_op_s  = ALU_ADD;
    dec_imm_s = '0;
    dec_a_s   = 1'b0;
    dec_b_s   = 1'b0;
    dec_w_s   = 1'b0;
    dec_bad_s = 1'b0;
    case (opcode_s)
      OPC_OP_IMM: begin
        dec_b_s   = 1'b1;
        dec_op_s  = f3_op(funct3_s, 1'b0);
        dec_imm_s = imm_itype(instr_i);
        if (funct3_s == 3'b001) begin
          dec_imm_s = shamt6_s;
          dec_bad_s = (funct6_s != 6'b000000);
        end else if (funct3_s == 3'b101) begin
          dec_imm_s = shamt6_s;
          if (funct6_s == 6'b000000) begin
            dec_op_s = ALU_SRL;
          end else if (funct6_s == 6'b010000) begin
            dec_op_s = ALU_SRA;
          end else begin
            dec_bad_s = 1'b1;
          end
        end else begin
          dec_bad_s = 1'b0;
        end
      end
      OPC_OP: begin
        dec_op_s  = f3_op(funct3_s, instr_i[30]);
        dec_bad_s = !((funct7_s == 7'b0000000) ||
                      ((funct7_s == 7'b0100000) &&
                       ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      end
      OPC_OP_IMM_32: begin
        dec_b_s = 1'b1;
        case (funct3_s)
          3'b000: begin
            dec_op_s  = ALU_ADD;
            dec_w_s   = 1'b1;
            dec_imm_s = imm_itype(instr_i);
          end
          3'b001: begin
            dec_op_s  = ALU_SLLW;
            dec_imm_s = shamt5_s;
            dec_bad_s = (funct7_s != 7'b0000000);
          end
          3'b101: begin
            dec_imm_s = shamt5_s;
            if (funct7_s == 7'b0000000) begin
              dec_op_s = ALU_SRLW;
            end else if (funct7_s == 7'b0100000) begin
              dec_op_s = ALU_SRAW;
            end else begin
              dec_bad_s = 1'b1;
            end
          end
          default: dec_bad_s = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        case (funct3_s)
          3'b000: begin
            dec_w_s = 1'b1;
            if (funct7_s == 7'b0000000) begin
              dec_op_s = ALU_ADD;
            end else if (funct7_s == 7'b0100000) begin
              dec_op_s = ALU_SUB;
            end else begin
              dec_bad_s = 1'b1;
            end
          end
          3'b001: begin
            dec_op_s  = ALU_SLLW;
            dec_bad_s = (funct7_s != 7'b0000000);
          end
          3'b101: begin
            if (funct7_s == 7'b0000000) begin
              dec_op_s = ALU_SRLW;
            end else if (funct7_s == 7'b0100000) begin
              dec_op_s = ALU_SRAW;
            end else begin
              dec_bad_s = 1'b1;
            end
          end
          default: dec_bad_s = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_op_s  = ALU_LUI;
        dec_b_s   = 1'b1;
        dec_imm_s = imm_utype(instr_i);
      end
      OPC_AUIPC: begin
        dec_op_s  = ALU_AUIPC;
        dec_a_s   = 1'b1;
        dec_b_s   = 1'b1;
        dec_imm_s = imm_utype(instr_i);
      end
      OPC_LOAD, OPC_JALR: begin
        dec_b_s   = 1'b1;
        dec_imm_s = imm_itype(instr_i);
      end
      OPC_STORE: begin
        dec_b_s   = 1'b1;
        dec_imm_s = imm_stype(instr_i);
      end
      OPC_BRANCH: begin
        dec_op_s  = ALU_SUB;
        dec_imm_s = imm_btype(instr_i);
      end
      OPC_JAL: begin
        dec_a_s   = 1'b1;
        dec_b_s   = 1'b1;
        dec_imm_s = imm_jtype(instr_i);
      end
      default: dec_bad_s = 1'b1;
    endcase
  end

  // An undecodable word collapses to a neutral ADD bundle flagged illegal.
  assign alu_op_o  = dec_bad_s ? ALU_ADD : dec_op_s;
  assign imm_o     = dec_bad_s ? '0      : dec_imm_s;
  assign a_sel_o   = dec_bad_s ? 1'b0    : dec_a_s;
  assign b_sel_o   = dec_bad_s ? 1'b0    : dec_b_s;
  assign w_op_o    = dec_bad_s ? 1'b0    : dec_w_s;
  assign illegal_o = dec_bad_s;

endmodule

// File: rtl/alu_ctrl_decode.sv
// ID/EX pipeline register around the combinational decoder, with valid/ready
// handshakes on both sides, flush and synchronous reset.
module alu_ctrl_decode
  import alu_ctrl_decode_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_CTRL_BITS-1:0] alu_op,
  output logic [DATA_BITS-1:0]     imm,
  output logic                     a_sel,
  output logic                     b_sel,
  output logic                     w_op,
  output logic                     illegal
);

  localparam id_ex_t RESET_BUNDLE = '{alu_op: ALU_ADD, imm: '0, a_sel: 1'b0,
                                      b_sel: 1'b0, w_op: 1'b0, illegal: 1'b0};

  id_ex_t dec_s;
  id_ex_t bundle_q;
  id_ex_t bundle_d;
  logic   valid_q;
  logic   valid_d;
  logic   accept_s;

  alu_op_dec u_dec (
    .instr_i   (instr),
    .alu_op_o  (dec_s.alu_op),
    .imm_o     (dec_s.imm),
    .a_sel_o   (dec_s.a_sel),
    .b_sel_o   (dec_s.b_sel),
    .w_op_o    (dec_s.w_op),
    .illegal_o (dec_s.illegal)
  );

  // The slot can take a new word when empty or when it is draining this cycle.
  assign in_ready = !valid_q | out_ready;
  assign accept_s = in_valid & in_ready;

  // Next state: flush wins over accept; a drain without refill empties the slot.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d  = 1'b1;
      bundle_d = dec_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register with synchronous reset overriding flush and accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= RESET_BUNDLE;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = bundle_q.alu_op;
  assign imm       = bundle_q.imm;
  assign a_sel     = bundle_q.a_sel;
  assign b_sel     = bundle_q.b_sel;
  assign w_op      = bundle_q.w_op;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Self-checking bench for alu_ctrl_decode: directed instruction vectors with
// hand-computed decode results, a reference model of the handshake register,
// and an every-cycle compare process.
module tb_alu_ctrl_decode;
  import alu_ctrl_decode_pkg::*;

  typedef struct packed {
    logic [31:0]              instr;
    logic [ALU_CTRL_BITS-1:0] op;
    logic [63:0]              imm;
    logic                     a;
    logic                     b;
    logic                     w;
    logic                     ill;
  } vec_t;

  localparam int NV = 18;

  logic                     clk = 1'b0;
  logic                     rst, flush, in_valid, out_ready;
  logic [31:0]              instr;
  logic                     in_ready, out_valid, a_sel, b_sel, w_op, illegal;
  logic [ALU_CTRL_BITS-1:0] alu_op;
  logic [63:0]              imm;

  vec_t vecs [NV];
  int   cur_idx = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic chk_en = 1'b0;

  // Reference model state.
  logic m_valid = 1'b0;
  logic m_known = 1'b0;
  logic m_rdy;
  vec_t m_f;

  alu_ctrl_decode dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .imm(imm), .a_sel(a_sel), .b_sel(b_sel), .w_op(w_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic v, input int idx, input logic ordy, input logic fl, input logic r);
    in_valid  = v;
    cur_idx   = idx;
    instr     = vecs[idx].instr;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_op"}, 64'(alu_op), 64'(ALU_ADD));
    chk({tag, "_imm"}, imm, 64'd0);
    chk({tag, "_flags"}, 64'({a_sel, b_sel, w_op, illegal}), 64'd0);
  endtask

  // Reference model of the ID/EX slot, updated on the active edge.
  always @(posedge clk) begin
    m_rdy = !m_valid || out_ready;
    if (rst) begin
      m_valid = 1'b0;
      m_f     = '{32'h0, ALU_ADD, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      m_known = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0;
      m_known = 1'b0;
    end else if (in_valid && m_rdy) begin
      m_valid = 1'b1;
      m_f     = vecs[cur_idx];
      m_known = 1'b1;
    end else if (out_ready) begin
      if (m_valid) m_known = 1'b0;
      m_valid = 1'b0;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_known) begin
        chk("alu_op", 64'(alu_op), 64'(m_f.op));
        chk("imm", imm, m_f.imm);
        chk("a_sel", 64'(a_sel), 64'(m_f.a));
        chk("b_sel", 64'(b_sel), 64'(m_f.b));
        chk("w_op", 64'(w_op), 64'(m_f.w));
        chk("illegal", 64'(illegal), 64'(m_f.ill));
      end
    end
  end

  initial begin
    //                instr         op         imm                     a     b     w     ill
    vecs[0]  = '{32'hFFF00093, ALU_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0}; // ADDI -1
    vecs[1]  = '{32'h402081B3, ALU_SUB,   64'h0,                   1'b0, 1'b0, 1'b0, 1'b0}; // SUB
    vecs[2]  = '{32'h43F0D093, ALU_SRA,   64'd63,                  1'b0, 1'b1, 1'b0, 1'b0}; // SRAI 63
    vecs[3]  = '{32'h123452B7, ALU_LUI,   64'h1234_5000,           1'b0, 1'b1, 1'b0, 1'b0}; // LUI
    vecs[4]  = '{32'h4050D09B, ALU_SRAW,  64'd5,                   1'b0, 1'b1, 1'b0, 1'b0}; // SRAIW 5
    vecs[5]  = '{32'h002081BB, ALU_ADD,   64'h0,                   1'b0, 1'b0, 1'b1, 1'b0}; // ADDW
    vecs[6]  = '{32'h0000007F, ALU_ADD,   64'h0,                   1'b0, 1'b0, 1'b0, 1'b1}; // bad opcode
    vecs[7]  = '{32'h80000097, ALU_AUIPC, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1, 1'b0, 1'b0}; // AUIPC
    vecs[8]  = '{32'hFE20AE23, ALU_ADD,   64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0}; // SW -4
    vecs[9]  = '{32'hFE208CE3, ALU_SUB,   64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ -8
    vecs[10] = '{32'h001000EF, ALU_ADD,   64'h800,                 1'b1, 1'b1, 1'b0, 1'b0}; // JAL +2048
    vecs[11] = '{32'h04109093, ALU_ADD,   64'h0,                   1'b0, 1'b0, 1'b0, 1'b1}; // SLLI bad funct6
    vecs[12] = '{32'h0020B1B3, ALU_SLTU,  64'h0,                   1'b0, 1'b0, 1'b0, 1'b0}; // SLTU
    vecs[13] = '{32'h0010909B, ALU_SLLW,  64'd1,                   1'b0, 1'b1, 1'b0, 1'b0}; // SLLIW 1
    vecs[14] = '{32'h402081BB, ALU_SUB,   64'h0,                   1'b0, 1'b0, 1'b1, 1'b0}; // SUBW
    vecs[15] = '{32'h022081B3, ALU_ADD,   64'h0,                   1'b0, 1'b0, 1'b0, 1'b1}; // MUL (bad funct7)
    vecs[16] = '{32'h00813083, ALU_ADD,   64'd8,                   1'b0, 1'b1, 1'b0, 1'b0}; // LD 8
    vecs[17] = '{32'h8000C093, ALU_XOR,   64'hFFFF_FFFF_FFFF_F800, 1'b0, 1'b1, 1'b0, 1'b0}; // XORI -2048

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = 32'h0;
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk_reset_vals("reset");

    // Back-to-back stream of every vector at full throughput.
    for (int i = 0; i < NV; i++) begin
      cyc(1'b1, i, 1'b1, 1'b0, 1'b0);
      chk("stream_valid", 64'(out_valid), 64'd1);
      if (i == 0) chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      if (i == 2) chk("srai_imm", imm, 64'd63);
      if (i == 3) chk("lui_imm", imm, 64'h0000_0000_1234_5000);
      if (i == 6) chk("ill_flag", 64'({illegal, alu_op}), 64'({1'b1, ALU_ADD}));
    end
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Back-pressure: ADDI held for three cycles while SUB waits.
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
      chk("stall_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    cyc(1'b1, 1, 1'b1, 1'b0, 1'b0);
    chk("release_op", 64'(alu_op), 64'(ALU_SUB));
    chk("release_valid", 64'(out_valid), 64'd1);

    // Flush while stalled with a new word presented.
    cyc(1'b1, 3, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_op", 64'(alu_op), 64'(ALU_LUI));
    cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("flush_discard", 64'(out_valid), 64'd0);

    // Reset in the middle of a stream.
    cyc(1'b1, 4, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b1, 1'b0, 1'b1);
    chk_reset_vals("midrst");
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Mixed handshake traffic with occasional flushes.
    for (int k = 0; k < 300; k++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 1'b0);
    end
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
